// File: rtl/seq_detect_param.sv
// Serial sequence detector: one switch bit per tick (MSB first) is compared against a loaded M-bit pattern.
// All outputs are registered, with 1 clk latency from tick. There is no backpressure: every tick consumes one bit.
module seq_detect_param #(
   parameter  int N      = 8,
   parameter  int M      = 4,
   parameter  int CNT_W  = 4,
   parameter  int FRAMED = 0,
   localparam int IW     = $clog2(N)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             tick,
   input  logic [N-1:0]     switches,
   input  logic [M-1:0]     pattern,
   input  logic             load,
   input  logic             ovl,
   output logic [IW-1:0]    bit_sel,
   output logic [N-1:0]     leds,
   output logic             z,
   output logic [CNT_W-1:0] match_cnt,
   output logic             frame_done,
   output logic             result
);

   localparam int FW = $clog2(M + 1);
   localparam logic [IW-1:0] LAST  = IW'(N - 1);
   localparam logic [FW-1:0] MFILL = FW'(M);

   typedef enum logic {FILLING, ARMED} state_t;

   state_t           state_q, state_d;
   logic [IW-1:0]    bit_sel_q, bit_sel_d;
   logic [N-1:0]     leds_q, leds_d;
   logic [M-2:0]     hist_q, hist_d;
   logic [FW-1:0]    fill_q, fill_d;
   logic [M-1:0]     pat_q, pat_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             z_q, z_d;
   logic             fd_q, fd_d;
   logic             res_q, res_d;
   logic             hit_q, hit_d;

   logic             b;
   logic [M-1:0]     h_nxt;
   logic [FW-1:0]    f_nxt;
   logic             arriving;
   logic             match;

   // Only M-1 history bits are kept; the newest bit completes the M-bit window.
   assign b        = switches[LAST - bit_sel_q];
   assign h_nxt    = {hist_q, b};
   assign arriving = (state_q == ARMED) || (fill_q == FW'(M - 1));
   assign f_nxt    = arriving ? MFILL : fill_q + 1'b1;
   assign match    = arriving && (h_nxt == pat_q);

   always_comb begin
      bit_sel_d = bit_sel_q;
      hist_d    = hist_q;
      fill_d    = fill_q;
      pat_d     = pat_q;
      cnt_d     = cnt_q;
      res_d     = res_q;
      hit_d     = hit_q;
      z_d       = 1'b0;
      fd_d      = 1'b0;
      if (load) begin
         pat_d     = pattern;
         bit_sel_d = '0;
         hist_d    = '0;
         fill_d    = '0;
         hit_d     = 1'b0;
         cnt_d     = '0;
      end else if (tick) begin
         hist_d    = h_nxt[M-2:0];
         fill_d    = (match && !ovl) ? '0 : f_nxt;
         bit_sel_d = (bit_sel_q == LAST) ? '0 : bit_sel_q + 1'b1;
         z_d       = match;
         if (match && (cnt_q != '1))
            cnt_d = cnt_q + 1'b1;
         if (bit_sel_q == LAST) begin
            fd_d  = 1'b1;
            res_d = hit_q | match;
            hit_d = 1'b0;
            if (FRAMED != 0) begin
               hist_d = '0;
               fill_d = '0;
            end
         end else begin
            hit_d = hit_q | match;
         end
      end
      state_d = (fill_d == MFILL) ? ARMED : FILLING;
      leds_d  = '0;
      leds_d[LAST - bit_sel_d] = 1'b1;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= FILLING;
         bit_sel_q <= '0;
         leds_q    <= {1'b1, {(N-1){1'b0}}};
         hist_q    <= '0;
         fill_q    <= '0;
         pat_q     <= '0;
         cnt_q     <= '0;
         z_q       <= 1'b0;
         fd_q      <= 1'b0;
         res_q     <= 1'b0;
         hit_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         bit_sel_q <= bit_sel_d;
         leds_q    <= leds_d;
         hist_q    <= hist_d;
         fill_q    <= fill_d;
         pat_q     <= pat_d;
         cnt_q     <= cnt_d;
         z_q       <= z_d;
         fd_q      <= fd_d;
         res_q     <= res_d;
         hit_q     <= hit_d;
      end
   end

   assign bit_sel    = bit_sel_q;
   assign leds       = leds_q;
   assign z          = z_q;
   assign match_cnt  = cnt_q;
   assign frame_done = fd_q;
   assign result     = res_q;

endmodule

// File: tb/tb_seq_detect_param.sv
// Bench for seq_detect_param: three instances (default, FRAMED=1, CNT_W=2) share stimulus; a reference model feeds a scoreboard.
module tb_seq_detect_param;

   logic       clk = 1'b0;
   logic       reset, tick, load, ovl;
   logic [7:0] switches;
   logic [3:0] pattern;

   logic [2:0] bs_a, bs_b, bs_c;
   logic [7:0] leds_a, leds_b, leds_c;
   logic       z_a, z_b, z_c, fd_a, fd_b, fd_c, res_a, res_b, res_c;
   logic [3:0] cnt_a, cnt_b;
   logic [1:0] cnt_c;

   int n_chk  = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   seq_detect_param #(.N(8), .M(4), .CNT_W(4), .FRAMED(0)) u_a (
      .clk(clk), .reset(reset), .tick(tick), .switches(switches), .pattern(pattern),
      .load(load), .ovl(ovl), .bit_sel(bs_a), .leds(leds_a), .z(z_a),
      .match_cnt(cnt_a), .frame_done(fd_a), .result(res_a));

   seq_detect_param #(.N(8), .M(4), .CNT_W(4), .FRAMED(1)) u_b (
      .clk(clk), .reset(reset), .tick(tick), .switches(switches), .pattern(pattern),
      .load(load), .ovl(ovl), .bit_sel(bs_b), .leds(leds_b), .z(z_b),
      .match_cnt(cnt_b), .frame_done(fd_b), .result(res_b));

   seq_detect_param #(.N(8), .M(4), .CNT_W(2), .FRAMED(0)) u_c (
      .clk(clk), .reset(reset), .tick(tick), .switches(switches), .pattern(pattern),
      .load(load), .ovl(ovl), .bit_sel(bs_c), .leds(leds_c), .z(z_c),
      .match_cnt(cnt_c), .frame_done(fd_c), .result(res_c));

   typedef struct {
      logic       z;
      logic [3:0] cnt;
      logic [2:0] bs;
      logic [7:0] leds;
      logic       fd;
      logic       res;
   } exp_t;

   exp_t sb_q[$];

   // Reference model state, one slot per instance
   logic [3:0] m_pat[3], m_hist[3], m_cnt[3];
   int         m_fill[3];
   logic [2:0] m_bs[3];
   logic       m_hit[3], m_res[3], m_z[3], m_fd[3];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_step();
      for (int i = 0; i < 3; i++) begin
         logic [3:0] cmax;
         logic       bit_in, m;
         logic [3:0] h;
         int         f;
         exp_t       e;
         cmax = (i == 2) ? 4'd3 : 4'd15;
         if (reset) begin
            m_pat[i] = 0; m_hist[i] = 0; m_fill[i] = 0; m_hit[i] = 0;
            m_bs[i] = 0; m_cnt[i] = 0; m_res[i] = 0; m_z[i] = 0; m_fd[i] = 0;
         end else if (load) begin
            m_pat[i] = pattern; m_hist[i] = 0; m_fill[i] = 0; m_hit[i] = 0;
            m_bs[i] = 0; m_cnt[i] = 0; m_z[i] = 0; m_fd[i] = 0;
         end else if (tick) begin
            bit_in = switches[7 - m_bs[i]];
            h = {m_hist[i][2:0], bit_in};
            f = (m_fill[i] >= 4) ? 4 : m_fill[i] + 1;
            m = (f == 4) && (h == m_pat[i]);
            m_z[i] = m;
            if (m && m_cnt[i] < cmax) m_cnt[i] = m_cnt[i] + 1;
            m_hist[i] = h;
            m_fill[i] = (m && !ovl) ? 0 : f;
            m_fd[i] = (m_bs[i] == 7);
            if (m_fd[i]) begin
               m_res[i] = m_hit[i] | m;
               m_hit[i] = 0;
               if (i == 1) begin
                  m_hist[i] = 0;
                  m_fill[i] = 0;
               end
            end else begin
               m_hit[i] = m_hit[i] | m;
            end
            m_bs[i] = (m_bs[i] == 7) ? 3'd0 : m_bs[i] + 3'd1;
         end else begin
            m_z[i] = 0; m_fd[i] = 0;
         end
         e.z = m_z[i]; e.cnt = m_cnt[i]; e.bs = m_bs[i];
         e.leds = 8'h80 >> m_bs[i]; e.fd = m_fd[i]; e.res = m_res[i];
         sb_q.push_back(e);
      end
   endtask

   task automatic check_all(input string tag);
      for (int i = 0; i < 3; i++) begin
         exp_t       e;
         logic       oz, ofd, ores;
         logic [3:0] ocnt;
         logic [2:0] obs_bs;
         logic [7:0] oleds;
         string      t;
         e = sb_q.pop_front();
         case (i)
            0: begin oz = z_a; ocnt = cnt_a; obs_bs = bs_a; oleds = leds_a; ofd = fd_a; ores = res_a; end
            1: begin oz = z_b; ocnt = cnt_b; obs_bs = bs_b; oleds = leds_b; ofd = fd_b; ores = res_b; end
            default: begin oz = z_c; ocnt = {2'b00, cnt_c}; obs_bs = bs_c; oleds = leds_c; ofd = fd_c; ores = res_c; end
         endcase
         t = $sformatf("%s/u%0d", tag, i);
         chk({t, ".z"},          32'(oz),     32'(e.z));
         chk({t, ".match_cnt"},  32'(ocnt),   32'(e.cnt));
         chk({t, ".bit_sel"},    32'(obs_bs), 32'(e.bs));
         chk({t, ".leds"},       32'(oleds),  32'(e.leds));
         chk({t, ".frame_done"}, 32'(ofd),    32'(e.fd));
         chk({t, ".result"},     32'(ores),   32'(e.res));
      end
   endtask

   task automatic step(input logic r, input logic l, input logic t, input string tag);
      reset = r; load = l; tick = t;
      model_step();
      @(posedge clk);
      #1;
      check_all(tag);
   endtask

   task automatic ticks(input int n, input string tag);
      for (int k = 0; k < n; k++) begin
         step(1'b0, 1'b0, 1'b1, $sformatf("%s_t%0d", tag, k + 1));
         step(1'b0, 1'b0, 1'b0, $sformatf("%s_idle%0d", tag, k + 1));
      end
   endtask

   initial begin
      reset = 1'b1; load = 1'b0; tick = 1'b0; ovl = 1'b1;
      switches = 8'h00; pattern = 4'b1011;

      // 1: reset
      step(1'b1, 1'b0, 1'b1, "reset1");
      step(1'b1, 1'b0, 1'b0, "reset2");
      chk("reset_bit_sel", 32'(bs_a), 32'd0);
      chk("reset_leds", 32'(leds_a), 32'h80);

      // 2: single match mid-frame
      step(1'b0, 1'b1, 1'b0, "load2");
      switches = 8'b1011_0000; ovl = 1'b1;
      ticks(8, "t2");
      chk("t2_result", 32'(res_a), 32'd1);
      chk("t2_match_cnt", 32'(cnt_a), 32'd1);

      // 3: overlap vs non-overlap
      step(1'b0, 1'b1, 1'b0, "load3a");
      switches = 8'b1011_0110; ovl = 1'b1;
      ticks(8, "t3ovl");
      chk("t3_ovl_cnt", 32'(cnt_a), 32'd2);
      step(1'b0, 1'b1, 1'b0, "load3b");
      ovl = 1'b0;
      ticks(8, "t3novl");
      chk("t3_novl_cnt", 32'(cnt_a), 32'd1);

      // 4: match spanning a frame boundary
      step(1'b0, 1'b1, 1'b0, "load4");
      switches = 8'b1000_0101; ovl = 1'b1;
      ticks(8, "t4");
      chk("t4_framed_result", 32'(res_b), 32'd0);
      step(1'b0, 1'b0, 1'b1, "t4_t9");
      chk("t4_span_z", 32'(z_a), 32'd1);
      chk("t4_framed_z", 32'(z_b), 32'd0);
      step(1'b0, 1'b0, 1'b0, "t4_after");

      // 5: load beats a simultaneous tick mid-frame
      step(1'b0, 1'b1, 1'b0, "load5");
      switches = 8'b1011_1011;
      ticks(5, "t5");
      pattern = 4'b0000;
      step(1'b0, 1'b1, 1'b1, "t5_load_tick");
      chk("t5_bit_sel", 32'(bs_a), 32'd0);
      chk("t5_match_cnt", 32'(cnt_a), 32'd0);

      // 6: counter saturation on the narrow instance
      pattern = 4'b1111;
      step(1'b0, 1'b1, 1'b0, "load6");
      switches = 8'hFF; ovl = 1'b1;
      ticks(8, "t6");
      chk("t6_cnt_sat", 32'(cnt_c), 32'd3);
      chk("t6_cnt_wide", 32'(cnt_a), 32'd5);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
